// File: rtl/calendar_set_ctrl_if.sv
// calendar_set_ctrl_if: button/tick inputs and calendar/display outputs of the set-mode controller
interface calendar_set_ctrl_if;
    logic       tick_1Hz;
    logic       end_of_day;
    logic       btn_mode;
    logic       btn_inc;
    logic       inc_month;
    logic       inc_day;
    logic       inc_year;
    logic       inc_century;
    logic       set_mode;
    logic [1:0] field_sel;
    logic       blink;
    logic       busy;
    modport slave (
        input  tick_1Hz, end_of_day, btn_mode, btn_inc,
        output inc_month, inc_day, inc_year, inc_century, set_mode, field_sel, blink, busy
    );
    modport master (
        output tick_1Hz, end_of_day, btn_mode, btn_inc,
        input  inc_month, inc_day, inc_year, inc_century, set_mode, field_sel, blink, busy
    );
endinterface

// File: rtl/calendar_set_ctrl.sv
// calendar_set_ctrl: debounced MODE/INC set-mode controller issuing tick-aligned calendar inc requests
module calendar_set_ctrl #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int TIMEOUT_S  = 10,
    parameter int ARM_CYC    = 4,
    parameter int HOLD_CYC   = 4,
    parameter int PEND_MAX   = 7
) (
    input logic                clk_100MHz,
    input logic                reset_n,
    calendar_set_ctrl_if.slave bus_if
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_S + 1);
    localparam int CW = $clog2((ARM_CYC > HOLD_CYC ? ARM_CYC : HOLD_CYC) + 1);
    localparam int PW = $clog2(PEND_MAX + 1);

    typedef enum logic [2:0] {IDLE, SET_MONTH, SET_DAY, SET_YEAR, SET_CENT} mode_t;
    typedef enum logic [1:0] {R_IDLE, R_ARM, R_WAIT, R_HOLD} req_t;

    logic [1:0]    btn_raw;
    logic [1:0]    sync_q [2];
    logic [DW-1:0] deb_cnt_q [2];
    logic [1:0]    lvl_q, press_q;
    logic          mode_press, inc_press;
    logic          tick_q, tick_qq, tick_rise, phase_q;
    mode_t         mode_q, mode_d;
    logic [TW-1:0] to_q, to_d;
    logic [PW-1:0] pend_q, pend_d, pend_dec;
    logic          in_set, timeout, start;
    req_t          req_q, req_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    fld_q, fld_d, field;
    logic [3:0]    inc_v;

    assign btn_raw    = {bus_if.btn_inc, bus_if.btn_mode};
    assign mode_press = press_q[0];
    assign inc_press  = press_q[1] & ~press_q[0];
    assign tick_rise  = tick_q & ~tick_qq;

    // Two-flop synchroniser and debounce per button; a press is an accepted 0->1 level change
    always_ff @(posedge clk_100MHz) begin
        for (int b = 0; b < 2; b++) begin
            if (!reset_n) begin
                sync_q[b]    <= 2'b00;
                deb_cnt_q[b] <= '0;
                lvl_q[b]     <= 1'b0;
                press_q[b]   <= 1'b0;
            end else begin
                sync_q[b]  <= {sync_q[b][0], btn_raw[b]};
                press_q[b] <= 1'b0;
                if (sync_q[b][1] == lvl_q[b]) begin
                    deb_cnt_q[b] <= '0;
                end else if (deb_cnt_q[b] == DW'(DEB_CYCLES - 1)) begin
                    deb_cnt_q[b] <= '0;
                    lvl_q[b]     <= sync_q[b][1];
                    press_q[b]   <= sync_q[b][1];
                end else begin
                    deb_cnt_q[b] <= deb_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    // State registers for mode/request FSMs, tick edge detect and blink phase
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            tick_q  <= 1'b0;
            tick_qq <= 1'b0;
            phase_q <= 1'b0;
            mode_q  <= IDLE;
            to_q    <= '0;
            pend_q  <= '0;
            req_q   <= R_IDLE;
            cnt_q   <= '0;
            fld_q   <= 2'd0;
        end else begin
            tick_q  <= bus_if.tick_1Hz;
            tick_qq <= tick_q;
            phase_q <= phase_q ^ tick_rise;
            mode_q  <= mode_d;
            to_q    <= to_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            fld_q   <= fld_d;
        end
    end

    // Mode walk, inactivity timeout and pending-press bookkeeping; MODE wins over INC
    always_comb begin
        mode_d   = mode_q;
        to_d     = to_q;
        timeout  = 1'b0;
        in_set   = mode_q != IDLE;
        field    = in_set ? 2'(mode_q - 3'd1) : 2'd0;
        start    = req_q == R_IDLE && pend_q != '0 && !bus_if.end_of_day;
        pend_dec = pend_q - PW'(start);
        if (mode_press) begin
            mode_d = mode_q == SET_CENT ? IDLE : mode_t'(mode_q + 3'd1);
            to_d   = '0;
        end else if (in_set) begin
            if (inc_press) begin
                to_d = '0;
            end else if (tick_rise) begin
                timeout = to_q == TW'(TIMEOUT_S - 1);
                mode_d  = timeout ? IDLE : mode_q;
                to_d    = timeout ? '0 : to_q + 1'b1;
            end
        end
        pend_d = (mode_press || timeout) ? '0 :
                 (inc_press && in_set && pend_dec != PW'(PEND_MAX)) ? pend_dec + 1'b1 : pend_dec;
    end

    // Request sequencer: hold inc_* through ARM, wait for a tick rise, then hold a few cycles more
    always_comb begin
        req_d = req_q;
        cnt_d = cnt_q;
        fld_d = fld_q;
        unique case (req_q)
            R_IDLE: begin
                req_d = start ? R_ARM : R_IDLE;
                fld_d = start ? field : fld_q;
                cnt_d = '0;
            end
            R_ARM: begin
                req_d = cnt_q == CW'(ARM_CYC - 1) ? R_WAIT : R_ARM;
                cnt_d = cnt_q == CW'(ARM_CYC - 1) ? '0 : cnt_q + 1'b1;
            end
            R_WAIT: req_d = tick_rise ? R_HOLD : R_WAIT;
            R_HOLD: begin
                req_d = cnt_q == CW'(HOLD_CYC - 1) ? R_IDLE : R_HOLD;
                cnt_d = cnt_q == CW'(HOLD_CYC - 1) ? '0 : cnt_q + 1'b1;
            end
            default: req_d = R_IDLE;
        endcase
    end

    assign inc_v              = req_q != R_IDLE ? 4'b0001 << fld_q : 4'b0000;
    assign bus_if.inc_month   = inc_v[0];
    assign bus_if.inc_day     = inc_v[1];
    assign bus_if.inc_year    = inc_v[2];
    assign bus_if.inc_century = inc_v[3];
    assign bus_if.set_mode    = in_set;
    assign bus_if.field_sel   = field;
    assign bus_if.blink       = in_set & phase_q;
    assign bus_if.busy        = req_q != R_IDLE || pend_q != '0;
endmodule

// File: tb/tb_calendar_set_ctrl.sv
// tb_calendar_set_ctrl: randomized scenario bench with a pulse-level model of the set controller
module tb_calendar_set_ctrl;
    localparam int DEB = 8, TO = 10, ARM = 4, HOLD = 4, PMAX = 7, TPER = 24;

    typedef struct {int f; int tk; int post;} pulse_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tick_en = 1'b0;
    logic [3:0] incv;
    int tph = 0, tick_n = 0, m = 0;
    int vectors = 0, miscompares = 0, onehot_err = 0;
    int run_c [4], post_c [4], tk_c [4];
    pulse_t pq [$];

    calendar_set_ctrl_if bus_if ();

    calendar_set_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_S(TO), .ARM_CYC(ARM), .HOLD_CYC(HOLD), .PEND_MAX(PMAX)) dut (
        .clk_100MHz(clk),
        .reset_n   (reset_n),
        .bus_if    (bus_if)
    );

    always #5 clk = ~clk;

    assign incv = {bus_if.inc_century, bus_if.inc_year, bus_if.inc_day, bus_if.inc_month};

    // 1-cycle tick every TPER cycles while enabled
    initial begin
        bus_if.tick_1Hz = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (tick_en) begin
                tph = (tph + 1) % TPER;
                bus_if.tick_1Hz = tph == 0;
                if (tph == 0) tick_n++;
            end else begin
                bus_if.tick_1Hz = 1'b0;
            end
        end
    end

    // Pulse recorder: a tick counts once inc has been high ARM-1 samples before it; post = samples from tick to drop
    initial begin
        for (int f = 0; f < 4; f++) begin run_c[f] = 0; post_c[f] = 0; tk_c[f] = 0; end
        forever begin
            @(negedge clk);
            if ($countones(incv) > 1) onehot_err++;
            for (int f = 0; f < 4; f++) begin
                if (incv[f]) begin
                    if (bus_if.tick_1Hz && run_c[f] >= ARM - 1) begin tk_c[f]++; post_c[f] = 0; end
                    run_c[f]++;
                    post_c[f]++;
                end else if (run_c[f] != 0) begin
                    pq.push_back('{f, tk_c[f], post_c[f]});
                    run_c[f] = 0; tk_c[f] = 0; post_c[f] = 0;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press(input bit is_mode);
        if (is_mode) bus_if.btn_mode = 1'b1; else bus_if.btn_inc = 1'b1;
        cyc(DEB + 4 + $urandom_range(0, 3));
        bus_if.btn_mode = 1'b0;
        bus_if.btn_inc = 1'b0;
        cyc(DEB + 4 + $urandom_range(0, 3));
        if (is_mode) m = (m + 1) % 5;
    endtask

    task automatic wait_idle(output bit ok);
        int g = 0;
        while ((bus_if.busy || incv != 0) && g < 2000) begin cyc(1); g++; end
        ok = g < 2000;
        cyc(3);
    endtask

    task automatic count_pulses(input int f, output int good, output int bad);
        pulse_t p;
        good = 0; bad = 0;
        while (pq.size() != 0) begin
            p = pq.pop_front();
            if (p.f == f && p.tk == 1 && p.post == HOLD + 2) good++; else bad++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick_en = 1'b1;
        cyc(3);
        vectors++;
        if ({incv, bus_if.set_mode, bus_if.field_sel, bus_if.blink, bus_if.busy} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got inc=%b set=%b fs=%0d blink=%b busy=%b, want all 0",
                     incv, bus_if.set_mode, bus_if.field_sel, bus_if.blink, bus_if.busy);
        end
        reset_n = 1'b1;
        cyc(60);
        vectors++;
        if ({incv, bus_if.set_mode, bus_if.field_sel, bus_if.blink, bus_if.busy} !== 9'd0) begin
            miscompares++;
            $display("FAIL post_reset_quiet: got inc=%b set=%b fs=%0d blink=%b busy=%b, want all 0",
                     incv, bus_if.set_mode, bus_if.field_sel, bus_if.blink, bus_if.busy);
        end
    endtask

    task automatic test_debounce;
        bus_if.btn_mode = 1'b1;
        cyc(5);
        bus_if.btn_mode = 1'b0;
        cyc(20);
        vectors++;
        if (bus_if.set_mode !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_ignored: set_mode=%b want 0", bus_if.set_mode);
        end
        bus_if.btn_mode = 1'b1;
        cyc(20);
        m = 1;
        vectors++;
        if (bus_if.set_mode !== 1'b1 || bus_if.field_sel !== 2'd0) begin
            miscompares++;
            $display("FAIL debounced_mode: set=%b fs=%0d want 1/0", bus_if.set_mode, bus_if.field_sel);
        end
        bus_if.btn_mode = 1'b0;
        cyc(DEB + 6);
    endtask

    task automatic test_single_inc;
        int g, good, bad, off;
        bit ok;
        press(1'b1);
        vectors++;
        if (bus_if.field_sel !== 2'd1) begin
            miscompares++;
            $display("FAIL field_day: fs=%0d want 1", bus_if.field_sel);
        end
        for (int k = 0; k < 4; k++) begin
            off = k == 0 ? 12 : $urandom_range(0, TPER - 1);
            g = 0;
            while (tph != (TPER - 1 - off + TPER) % TPER && g < 2 * TPER) begin cyc(1); g++; end
            press(1'b0);
            wait_idle(ok);
            count_pulses(1, good, bad);
            vectors++;
            if (!ok || good !== 1 || bad !== 0) begin
                miscompares++;
                $display("FAIL single_inc_day off=%0d: done=%b good=%0d bad=%0d want 1/1/0", off, ok, good, bad);
            end
        end
    endtask

    task automatic test_saturate;
        int n, good, bad;
        bit ok;
        press(1'b1);
        bus_if.end_of_day = 1'b1;
        n = $urandom_range(8, 12);
        repeat (n) press(1'b0);
        cyc(5);
        vectors++;
        if (bus_if.busy !== 1'b1 || incv !== 4'd0) begin
            miscompares++;
            $display("FAIL eod_inhibit: busy=%b inc=%b want 1/0000", bus_if.busy, incv);
        end
        bus_if.end_of_day = 1'b0;
        wait_idle(ok);
        count_pulses(2, good, bad);
        vectors++;
        if (!ok || good !== (n < PMAX ? n : PMAX) || bad !== 0) begin
            miscompares++;
            $display("FAIL saturate_year n=%0d: done=%b good=%0d bad=%0d want %0d good", n, ok, good, bad, PMAX);
        end
        vectors++;
        if (bus_if.set_mode !== 1'b1 || bus_if.field_sel !== 2'd2) begin
            miscompares++;
            $display("FAIL still_year: set=%b fs=%0d want 1/2", bus_if.set_mode, bus_if.field_sel);
        end
    endtask

    task automatic test_mode_in_flight;
        int good, bad;
        bit ok;
        press(1'b1);
        press(1'b1);
        vectors++;
        if (bus_if.set_mode !== 1'b0 || bus_if.field_sel !== 2'd0) begin
            miscompares++;
            $display("FAIL wrap_idle: set=%b fs=%0d want 0/0", bus_if.set_mode, bus_if.field_sel);
        end
        press(1'b0);
        cyc(5);
        vectors++;
        if (bus_if.busy !== 1'b0 || incv !== 4'd0 || pq.size() != 0) begin
            miscompares++;
            $display("FAIL idle_inc_ignored: busy=%b inc=%b pulses=%0d want 0", bus_if.busy, incv, pq.size());
        end
        press(1'b1);
        tick_en = 1'b0;
        press(1'b0);
        press(1'b0);
        press(1'b1);
        vectors++;
        if (bus_if.field_sel !== 2'd1 || incv !== 4'b0001 || bus_if.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL in_flight: fs=%0d inc=%b busy=%b want 1/0001/1", bus_if.field_sel, incv, bus_if.busy);
        end
        tick_en = 1'b1;
        wait_idle(ok);
        count_pulses(0, good, bad);
        vectors++;
        if (!ok || good !== 1 || bad !== 0) begin
            miscompares++;
            $display("FAIL month_completes: done=%b good=%0d bad=%0d want 1 good 0 bad", ok, good, bad);
        end
    endtask

    task automatic test_timeout;
        int base, g, good, bad;
        logic prev_blink;
        bit ok;
        tick_en = 1'b0;
        press(1'b1);
        press(1'b1);
        vectors++;
        if (bus_if.field_sel !== 2'd3) begin
            miscompares++;
            $display("FAIL field_cent: fs=%0d want 3", bus_if.field_sel);
        end
        base = tick_n;
        prev_blink = bus_if.blink;
        tick_en = 1'b1;
        for (int i = 1; i <= TO; i++) begin
            g = 0;
            while (tick_n < base + i && g < 3 * TPER) begin cyc(1); g++; end
            vectors++;
            if (tick_n < base + i || bus_if.set_mode !== 1'b1) begin
                miscompares++;
                $display("FAIL timeout_hold tick=%0d: set=%b want 1", i, bus_if.set_mode);
            end
            if (i < TO) begin
                cyc(3);
                vectors++;
                if (bus_if.blink === prev_blink) begin
                    miscompares++;
                    $display("FAIL blink_toggle tick=%0d: blink=%b want %b", i, bus_if.blink, ~prev_blink);
                end
                prev_blink = bus_if.blink;
            end
        end
        cyc(3);
        m = 0;
        vectors++;
        if (bus_if.set_mode !== 1'b0 || bus_if.blink !== 1'b0 || bus_if.field_sel !== 2'd0) begin
            miscompares++;
            $display("FAIL timeout_exit: set=%b blink=%b fs=%0d want 0/0/0", bus_if.set_mode, bus_if.blink, bus_if.field_sel);
        end
        press(1'b1);
        bus_if.end_of_day = 1'b1;
        press(1'b0);
        cyc(60);
        vectors++;
        if (bus_if.busy !== 1'b1 || incv !== 4'd0 || pq.size() != 0) begin
            miscompares++;
            $display("FAIL eod_wait: busy=%b inc=%b pulses=%0d want 1/0000/0", bus_if.busy, incv, pq.size());
        end
        bus_if.end_of_day = 1'b0;
        wait_idle(ok);
        count_pulses(0, good, bad);
        vectors++;
        if (!ok || good !== 1 || bad !== 0) begin
            miscompares++;
            $display("FAIL eod_release: done=%b good=%0d bad=%0d want 1 good", ok, good, bad);
        end
    endtask

    task automatic test_random;
        int k, n, good, bad;
        bit ok;
        for (int r = 0; r < 3; r++) begin
            k = $urandom_range(1, 4);
            repeat (k) press(1'b1);
            while (m == 0) press(1'b1);
            n = $urandom_range(1, 4);
            repeat (n) begin
                press(1'b0);
                cyc($urandom_range(0, 30));
            end
            wait_idle(ok);
            count_pulses(m - 1, good, bad);
            vectors++;
            if (!ok || good !== n || bad !== 0 || bus_if.field_sel !== 2'(m - 1)) begin
                miscompares++;
                $display("FAIL random_round%0d field=%0d: done=%b good=%0d bad=%0d fs=%0d want %0d good",
                         r, m - 1, ok, good, bad, bus_if.field_sel, n);
            end
        end
    endtask

    task automatic test_mid_reset;
        int g = 0;
        if (m == 0) press(1'b1);
        bus_if.btn_inc = 1'b1;
        while (incv == 4'd0 && g < 200) begin cyc(1); g++; end
        bus_if.btn_inc = 1'b0;
        cyc(1);
        reset_n = 1'b0;
        cyc(1);
        vectors++;
        if (g >= 200 || incv !== 4'd0 || bus_if.busy !== 1'b0 || bus_if.set_mode !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: started=%b inc=%b busy=%b set=%b want 0", g < 200, incv, bus_if.busy, bus_if.set_mode);
        end
        cyc(1);
        reset_n = 1'b1;
        m = 0;
        cyc(DEB + 6);
        pq.delete();
    endtask

    initial begin
        bus_if.btn_mode = 1'b0;
        bus_if.btn_inc = 1'b0;
        bus_if.end_of_day = 1'b0;
        test_reset();
        test_debounce();
        test_single_inc();
        test_saturate();
        test_mode_in_flight();
        test_timeout();
        test_random();
        test_mid_reset();
        vectors++;
        if (onehot_err !== 0) begin
            miscompares++;
            $display("FAIL inc_onehot: %0d samples with >1 inc high, want 0", onehot_err);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
